// File: rtl/fft_stage_scheduler.sv
// fft_stage_scheduler: hands start pulses to the loader (unit 0), the LOG_N
// butterfly stages and the unloader (unit LOG_N+1), and tracks which unit
// owns each of the LOG_N+1 stage memories. Unit u reads mem u-1, writes mem u.
// Optional feature macro: FFT_SCHED_WATCHDOG_EN (per-unit job watchdog, WD_MAX).
module fft_stage_scheduler #(
    parameter int N     = 8,
    parameter int LOG_N = $clog2(N)
`ifdef FFT_SCHED_WATCHDOG_EN
    , parameter int WD_MAX = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_avail,
    input  logic             out_ready,
    input  logic [LOG_N+1:0] unit_done,
    output logic [LOG_N+1:0] unit_start,
    output logic [LOG_N+1:0] unit_busy,
    output logic [LOG_N:0]   mem_full,
    output logic             idle,
    output logic [15:0]      frame_cnt,
    output logic             error
);

    localparam int S = LOG_N;
    localparam int M = S + 1;
    localparam int U = S + 2;

    typedef enum logic [1:0] {
        MEM_EMPTY,
        MEM_WRITING,
        MEM_FULL,
        MEM_READING
    } mem_state_t;

    mem_state_t     mem_q [M];
    mem_state_t     mem_d [M];
    logic [U-1:0]   busy_q, busy_d;
    logic [U-1:0]   start_q, start_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [U-1:0]   ready_in, free_out, done_ok;

`ifdef FFT_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_MAX + 1);
    logic [WD_W-1:0] wd_q [U];
    logic [WD_W-1:0] wd_d [U];
    logic [U-1:0]    timeout;
`endif

    // State register: memory ownership, unit busy flags, start pulses, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < M; k++) mem_q[k] <= MEM_EMPTY;
            busy_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef FFT_SCHED_WATCHDOG_EN
            for (int unsigned u = 0; u < U; u++) wd_q[u] <= '0;
`endif
        end else begin
            for (int unsigned k = 0; k < M; k++) mem_q[k] <= mem_d[k];
            busy_q  <= busy_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef FFT_SCHED_WATCHDOG_EN
            for (int unsigned u = 0; u < U; u++) wd_q[u] <= wd_d[u];
`endif
        end
    end

    // Next-state: start eligibility from registered state, then done/timeout effects.
    always_comb begin
        for (int unsigned k = 0; k < M; k++) mem_d[k] = mem_q[k];
        busy_d   = busy_q;
        start_d  = '0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_ok  = '0;
        ready_in = '0;
        free_out = '0;

        // Unit u's input is mem u-1 (loader: in_avail); output is mem u (unloader: out_ready).
        ready_in[0]   = in_avail;
        free_out[U-1] = out_ready;
        for (int unsigned k = 0; k < M; k++) begin
            ready_in[k+1] = (mem_q[k] == MEM_FULL);
            free_out[k]   = (mem_q[k] == MEM_EMPTY);
        end

        for (int unsigned u = 0; u < U; u++) begin
            if (!busy_q[u] && ready_in[u] && free_out[u]) begin
                start_d[u] = 1'b1;
                busy_d[u]  = 1'b1;
            end
            if (unit_done[u]) begin
                if (busy_q[u]) begin
                    done_ok[u] = 1'b1;
                    busy_d[u]  = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // Each memory sees at most one event per cycle; a producer's done is applied
        // last so a coincident consumer done can never leave the memory EMPTY.
        for (int unsigned k = 0; k < M; k++) begin
            if (start_d[k])   mem_d[k] = MEM_WRITING;
            if (start_d[k+1]) mem_d[k] = MEM_READING;
            if (done_ok[k+1]) mem_d[k] = MEM_EMPTY;
            if (done_ok[k])   mem_d[k] = MEM_FULL;
        end

        if (done_ok[U-1]) cnt_d = cnt_q + 16'd1;

`ifdef FFT_SCHED_WATCHDOG_EN
        timeout = '0;
        for (int unsigned u = 0; u < U; u++) begin
            wd_d[u] = wd_q[u];
            if (start_d[u]) begin
                wd_d[u] = '0;
            end else if (busy_q[u] && !unit_done[u]) begin
                if (wd_q[u] == WD_W'(WD_MAX - 1)) begin
                    timeout[u] = 1'b1;
                    busy_d[u]  = 1'b0;
                    err_d      = 1'b1;
                    wd_d[u]    = '0;
                end else begin
                    wd_d[u] = wd_q[u] + 1'b1;
                end
            end
        end
        // An abandoned job hands its input frame back and discards its partial output.
        for (int unsigned k = 0; k < M; k++) begin
            if (timeout[k+1]) mem_d[k] = MEM_FULL;
            if (timeout[k])   mem_d[k] = MEM_EMPTY;
        end
`endif
    end

    // Status outputs derived from registered ownership state.
    always_comb begin
        idle = (busy_q == '0);
        for (int unsigned k = 0; k < M; k++) begin
            mem_full[k] = (mem_q[k] == MEM_FULL);
            if (mem_q[k] != MEM_EMPTY) idle = 1'b0;
        end
    end

    assign unit_start = start_q;
    assign unit_busy  = busy_q;
    assign frame_cnt  = cnt_q;
    assign error      = err_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Bench for fft_stage_scheduler: emulates the units with randomized job
// latencies and checks every cycle against a frame-position reference model.
module tb_fft_stage_scheduler;

    localparam int LOG_N = 3;
    localparam int U = LOG_N + 2;
    localparam int M = LOG_N + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_avail = 1'b0;
    logic             out_ready = 1'b0;
    logic [U-1:0]     unit_done = '0;
    logic [U-1:0]     unit_start, unit_busy;
    logic [M-1:0]     mem_full;
    logic             idle, error;
    logic [15:0]      frame_cnt;

    fft_stage_scheduler #(.N(8), .LOG_N(LOG_N)) dut (
        .clk(clk), .rst(rst), .in_avail(in_avail), .out_ready(out_ready),
        .unit_done(unit_done), .unit_start(unit_start), .unit_busy(unit_busy),
        .mem_full(mem_full), .idle(idle), .frame_cnt(frame_cnt), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: each frame in the pipeline has a position.
    // Position 2u = being processed by unit u; 2k+1 = resting complete in mem k.
    int          pos[$];
    int          m_cnt = 0;
    bit          m_err = 0;
    logic [U-1:0] exp_st = '0;

    // Unit emulation: countdown to the done pulse, plus directed injected pulses.
    int           cd[U];
    logic [U-1:0] inj = '0;
    int           lat_lo = 1, lat_hi = 4;

    function automatic int find_pos(int p);
        foreach (pos[i]) if (pos[i] == p) return i;
        return -1;
    endfunction

    function automatic bit mem_free(int k);
        // empty: nothing resting there, nobody writing it, nobody reading it
        return find_pos(2*k+1) < 0 && find_pos(2*k) < 0 && find_pos(2*k+2) < 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [U-1:0] d, input bit ia, input bit orr);
        logic [U-1:0] st;
        logic [U-1:0] dv;
        int idx;
        st = '0;
        dv = '0;
        for (int u = 0; u < U; u++) begin
            bit in_ok, out_ok;
            in_ok  = (u == 0) ? ia : (find_pos(2*u-1) >= 0);
            out_ok = (u == U-1) ? orr : mem_free(u);
            st[u]  = (find_pos(2*u) < 0) && in_ok && out_ok;
            if (d[u]) begin
                if (find_pos(2*u) >= 0) dv[u] = 1'b1;
                else m_err = 1'b1;
            end
        end
        for (int u = 0; u < U; u++) begin
            if (dv[u]) begin
                idx = find_pos(2*u);
                if (u == U-1) begin
                    pos.delete(idx);
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    pos[idx] = 2*u+1;
                end
            end
        end
        for (int u = 0; u < U; u++) begin
            if (st[u]) begin
                if (u == 0) pos.push_back(0);
                else pos[find_pos(2*u-1)] = 2*u;
            end
        end
        exp_st = st;
    endtask

    task automatic step();
        logic [U-1:0] d;
        logic [U-1:0] eb;
        logic [M-1:0] ef;
        d = '0;
        for (int u = 0; u < U; u++) begin
            d[u] = (cd[u] == 1) || inj[u];
            if (cd[u] > 0) cd[u]--;
        end
        if (rst) begin
            d = '0;
            pos.delete();
            m_cnt = 0;
            m_err = 0;
            exp_st = '0;
            for (int u = 0; u < U; u++) cd[u] = 0;
        end else begin
            model_edge(d, in_avail, out_ready);
        end
        unit_done = d;
        @(posedge clk);
        #1;
        cyc++;
        eb = '0;
        ef = '0;
        for (int u = 0; u < U; u++) eb[u] = find_pos(2*u) >= 0;
        for (int k = 0; k < M; k++) ef[k] = find_pos(2*k+1) >= 0;
        chk("unit_start", 32'(unit_start), 32'(exp_st));
        chk("unit_busy", 32'(unit_busy), 32'(eb));
        chk("mem_full", 32'(mem_full), 32'(ef));
        chk("idle", 32'(idle), 32'(pos.size() == 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("error", 32'(error), 32'(m_err));
        for (int u = 0; u < U; u++)
            if (exp_st[u]) cd[u] = $urandom_range(lat_hi, lat_lo) + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        in_avail = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && pos.size() != 0; i++) step();
        chk(tag, 32'(idle), 32'd1);
    endtask

    int t_start[U];
    int starts0;

    initial begin
        for (int u = 0; u < U; u++) cd[u] = 0;

        // 1: reset then idle
        do_reset();
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_mem_full", 32'(mem_full), 32'd0);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd0);
        step();
        chk("t1_start", 32'(unit_start), 32'd0);

        // 2: single frame, every unit takes 4 cycles
        lat_lo = 4; lat_hi = 4;
        in_avail = 1'b1;
        out_ready = 1'b1;
        for (int u = 0; u < U; u++) t_start[u] = -1;
        step();
        chk("t2_start0", 32'(unit_start[0]), 32'd1);
        t_start[0] = cyc;
        in_avail = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            step();
            for (int u = 1; u < U; u++) if (unit_start[u]) t_start[u] = cyc;
        end
        for (int u = 1; u < U; u++)
            chk("t2_start_gap", 32'(t_start[u] - t_start[u-1]), 32'd6);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t2_idle", 32'(idle), 32'd1);

        // 3: continuous input, ten frames
        do_reset();
        starts0 = 0;
        in_avail = 1'b1;
        for (int i = 0; i < 600 && starts0 < 10; i++) begin
            step();
            if (unit_start[0]) starts0++;
        end
        chk("t3_loads", 32'(starts0), 32'd10);
        drain(300, "t3_drain");
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd10);

        // 4: back-pressure fills the pipeline; 5: stray done is a sticky error
        do_reset();
        lat_lo = 1; lat_hi = 4;
        in_avail = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 80; i++) step();
        chk("t4_full", 32'(mem_full), 32'hF);
        chk("t4_busy", 32'(unit_busy), 32'd0);
        chk("t4_nostart", 32'(unit_start), 32'd0);
        inj = 5'b00100;
        step();
        inj = '0;
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_mem_full", 32'(mem_full), 32'hF);
        step();
        chk("t5_sticky", 32'(error), 32'd1);
        out_ready = 1'b1;
        step();
        chk("t4_release", 32'(unit_start[U-1]), 32'd1);
        drain(300, "t4_drain");

        // randomized traffic
        do_reset();
        lat_lo = 1; lat_hi = 6;
        for (int i = 0; i < 400; i++) begin
            in_avail  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain(400, "rand_drain");

        // 6: reset with three units busy
        do_reset();
        lat_lo = 3; lat_hi = 6;
        in_avail = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && $countones(unit_busy) < 3; i++) step();
        chk("t6_three_busy", 32'($countones(unit_busy) >= 3), 32'd1);
        do_reset();
        chk("t6_busy", 32'(unit_busy), 32'd0);
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_mem_full", 32'(mem_full), 32'd0);
        in_avail = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
